uart_fabric_sched: RTL and testbench

Sequencer and round-robin arbiter that shares the single fabric request/response port of a tile between two requesters: the UART gateway (requester 0) and a local debug/boot requester (requester 1). It holds at most one transaction outstanding. It sequences each request through issue, stall back-pressure and response return, and steers read data back to the originating requester. A response timeout guarantees forward progress. It sits between the UART I/O path and the tile's C2F fabric interface.

---
 rtl/uart_fabric_sched_pkg.sv | 24 ++
 rtl/uart_fabric_sched_if.sv | 53 +++++
 rtl/uart_fabric_sched_rr_arb2.sv | 31 +++
 rtl/uart_fabric_sched.sv | 131 +++++++++++++
 tb/tb_uart_fabric_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fabric_sched_pkg.sv
// Shared types and constants for the UART/debug fabric scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_fabric_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESP
    } t_fab_sched_state;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam logic        WR_OP    = 1'b1;
    localparam logic        RD_OP    = 1'b0;

    // Request fields latched at grant and replayed onto the fabric port.
    typedef struct packed {
        logic        opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } t_fab_req;

endpackage

// File: rtl/uart_fabric_sched_if.sv
// Bundle of the two requester ports, the fabric port and scheduler status.
// Latency: n/a (wiring only).
// Backpressure: requests held until rN_req_ready; fabric stalls via fab_rsp_stall.
// master = scheduler side, slave = requesters + fabric side.
interface uart_fabric_sched_if;
    logic        r0_req_valid;
    logic        r0_req_opcode;
    logic [31:0] r0_req_addr;
    logic [31:0] r0_req_data;
    logic        r0_req_ready;
    logic        r0_rsp_valid;
    logic [31:0] r0_rsp_data;

    logic        r1_req_valid;
    logic        r1_req_opcode;
    logic [31:0] r1_req_addr;
    logic [31:0] r1_req_data;
    logic        r1_req_ready;
    logic        r1_rsp_valid;
    logic [31:0] r1_rsp_data;

    logic        fab_req_valid;
    logic        fab_req_opcode;
    logic [31:0] fab_req_addr;
    logic [31:0] fab_req_data;
    logic        fab_rsp_stall;
    logic        fab_rsp_valid;
    logic [31:0] fab_rsp_data;

    logic        timeout_err;
    logic        stray_rsp;
    logic        busy;

    modport master (
        input  r0_req_valid, r0_req_opcode, r0_req_addr, r0_req_data,
        input  r1_req_valid, r1_req_opcode, r1_req_addr, r1_req_data,
        input  fab_rsp_stall, fab_rsp_valid, fab_rsp_data,
        output r0_req_ready, r0_rsp_valid, r0_rsp_data,
        output r1_req_ready, r1_rsp_valid, r1_rsp_data,
        output fab_req_valid, fab_req_opcode, fab_req_addr, fab_req_data,
        output timeout_err, stray_rsp, busy
    );

    modport slave (
        output r0_req_valid, r0_req_opcode, r0_req_addr, r0_req_data,
        output r1_req_valid, r1_req_opcode, r1_req_addr, r1_req_data,
        output fab_rsp_stall, fab_rsp_valid, fab_rsp_data,
        input  r0_req_ready, r0_rsp_valid, r0_rsp_data,
        input  r1_req_ready, r1_rsp_valid, r1_rsp_data,
        input  fab_req_valid, fab_req_opcode, fab_req_addr, fab_req_data,
        input  timeout_err, stray_rsp, busy
    );
endinterface

// File: rtl/uart_fabric_sched_rr_arb2.sv
// Two-input round-robin arbiter with a registered priority pointer.
// Latency: grant is combinational from req; pointer updates on the upd_en edge.
// Backpressure: none; a non-granted request simply stays asserted.
// Ports: clk, rstn, req[1:0], upd_en, gnt[1:0] (one-hot or zero).
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt
);
    logic prio_r1;   // 1: requester 1 wins a tie

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prio_r1)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    // After serving N the other requester gets the tie-break.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_r1 <= 1'b0;
        end else if (upd_en && (gnt != 2'b00)) begin
            prio_r1 <= gnt[0];
        end
    end
endmodule

// File: rtl/uart_fabric_sched.sv
// Shares one fabric req/rsp port between the UART gateway (r0) and debug requester (r1).
// Latency: ready cycle 0, fab_req_valid cycle 1, write ack cycle 2, read rsp one cycle after fab_rsp_valid.
// Backpressure: one outstanding transaction; fab_rsp_stall holds ISSUE; timeout forces an ERR_DATA response.
// Ports: clk, rstn, bus (uart_fabric_sched_if.master: requester, fabric and status signals).
module uart_fabric_sched
    import uart_fabric_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    uart_fabric_sched_if.master     bus
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    t_fab_sched_state state;
    t_fab_req         req_q;
    t_fab_req         sel_req;
    logic             owner;        // 1: transaction belongs to r1
    logic [15:0]      tmo_cnt;
    logic             fab_vld_q;
    logic             busy_q;
    logic             rsp_vld_q;
    logic [31:0]      rsp_dat_q;
    logic             tmo_q;
    logic             stray_q;
    logic [1:0]       gnt;
    logic             grant_en;

    // Gating with rstn keeps the ready outputs low while reset is held.
    assign grant_en = (state == IDLE) && rstn;

    rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req    ({bus.r1_req_valid, bus.r0_req_valid}),
        .upd_en (grant_en),
        .gnt    (gnt)
    );

    assign bus.r0_req_ready = grant_en & gnt[0];
    assign bus.r1_req_ready = grant_en & gnt[1];

    always_comb begin
        if (gnt[1]) begin
            sel_req = '{opcode: bus.r1_req_opcode, addr: bus.r1_req_addr, data: bus.r1_req_data};
        end else begin
            sel_req = '{opcode: bus.r0_req_opcode, addr: bus.r0_req_addr, data: bus.r0_req_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            req_q     <= '{opcode: RD_OP, addr: 32'd0, data: 32'd0};
            owner     <= 1'b0;
            tmo_cnt   <= 16'd0;
            fab_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= 32'd0;
            tmo_q     <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            // Response and status flags are single-cycle pulses.
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= 32'd0;
            tmo_q     <= 1'b0;
            // Anything outside WAIT_RSP, including a reply after a timeout, is dropped.
            stray_q   <= bus.fab_rsp_valid && (state != WAIT_RSP);

            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        req_q     <= sel_req;
                        owner     <= gnt[1];
                        fab_vld_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.fab_rsp_stall) begin
                        fab_vld_q <= 1'b0;
                        if (req_q.opcode == WR_OP) begin
                            rsp_vld_q <= 1'b1;       // write ack carries zero data
                            state     <= RESP;
                        end else begin
                            tmo_cnt   <= 16'd0;
                            state     <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    // A real response on the expiry cycle takes precedence.
                    if (bus.fab_rsp_valid) begin
                        rsp_vld_q <= 1'b1;
                        rsp_dat_q <= bus.fab_rsp_data;
                        state     <= RESP;
                    end else if (tmo_cnt == TO_LAST) begin
                        rsp_vld_q <= 1'b1;
                        rsp_dat_q <= ERR_DATA;
                        tmo_q     <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // owner only changes in IDLE, when rsp_vld_q and rsp_dat_q are already zero.
    assign bus.r0_rsp_valid  = rsp_vld_q & ~owner;
    assign bus.r1_rsp_valid  = rsp_vld_q &  owner;
    assign bus.r0_rsp_data   = owner ? 32'd0 : rsp_dat_q;
    assign bus.r1_rsp_data   = owner ? rsp_dat_q : 32'd0;

    assign bus.fab_req_valid  = fab_vld_q;
    assign bus.fab_req_opcode = req_q.opcode;
    assign bus.fab_req_addr   = req_q.addr;
    assign bus.fab_req_data   = req_q.data;

    assign bus.timeout_err = tmo_q;
    assign bus.stray_rsp   = stray_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_uart_fabric_sched.sv
// Scoreboard bench for uart_fabric_sched with TIMEOUT_CYCLES=16.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
// Inline checks cover latency, stall hold, stray pulses and reset behaviour.
module tb_uart_fabric_sched;
    import uart_fabric_sched_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    uart_fabric_sched_if bus();

    uart_fabric_sched #(.TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        tmo;
    } exp_rsp_t;

    int       errors = 0;
    int       checks = 0;
    int       gq[$];
    exp_rsp_t rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_rsp(input int who, input logic [31:0] d, input logic t);
        exp_rsp_t e;
        e.who  = who;
        e.data = d;
        e.tmo  = t;
        rq.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns the granted requester and how many negedges it took.
    task automatic wait_any_ready(output int who, output int waited);
        who    = -1;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            waited++;
            if (bus.r0_req_ready) begin who = 0; break; end
            if (bus.r1_req_ready) begin who = 1; break; end
        end
        if (who < 0) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got no ready pulse in 40 cycles, expected one");
        end
    endtask

    // Monitor: every grant and response the DUT presents must match the queue head.
    initial begin
        int       g;
        exp_rsp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.r0_req_ready || bus.r1_req_ready) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", {30'd0, bus.r1_req_ready, bus.r0_req_ready}, 32'd0);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_order", {30'd0, bus.r1_req_ready, bus.r0_req_ready}, 32'd1 << g);
                    end
                end
                if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_rsp", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd0);
                    end else begin
                        e = rq.pop_front();
                        chk("rsp_owner", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd1 << e.who);
                        chk("rsp_data", (e.who == 1) ? bus.r1_rsp_data : bus.r0_rsp_data, e.data);
                        chk("rsp_timeout_err", {31'd0, bus.timeout_err}, {31'd0, e.tmo});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int          who;
        int          w;
        int          n0;
        int          n1;
        int          lat;
        logic [31:0] a;

        bus.r0_req_valid  = 1'b0;
        bus.r0_req_opcode = RD_OP;
        bus.r0_req_addr   = 32'd0;
        bus.r0_req_data   = 32'd0;
        bus.r1_req_valid  = 1'b0;
        bus.r1_req_opcode = RD_OP;
        bus.r1_req_addr   = 32'd0;
        bus.r1_req_data   = 32'd0;
        bus.fab_rsp_stall = 1'b0;
        bus.fab_rsp_valid = 1'b0;
        bus.fab_rsp_data  = 32'd0;

        // Reset state
        #3;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_fab_req_valid", {31'd0, bus.fab_req_valid}, 32'd0);
        chk("rst_fab_req_addr", bus.fab_req_addr, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd0);
        chk("rst_status", {30'd0, bus.timeout_err, bus.stray_rsp}, 32'd0);
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        next_cycle();

        // Single read on r0, fabric answers in cycle 3
        gq.push_back(0);
        push_rsp(0, 32'h1234_5678, 1'b0);
        bus.r0_req_valid  = 1'b1;
        bus.r0_req_opcode = RD_OP;
        bus.r0_req_addr   = 32'h0000_0100;
        bus.r0_req_data   = 32'hFFFF_FFFF;
        wait_any_ready(who, w);
        next_cycle();                                   // cycle 1
        bus.r0_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_fab_valid", {31'd0, bus.fab_req_valid}, 32'd1);
        chk("t1_fab_addr", bus.fab_req_addr, 32'h0000_0100);
        chk("t1_fab_opcode", {31'd0, bus.fab_req_opcode}, 32'd0);
        next_cycle();                                   // cycle 2
        next_cycle();                                   // cycle 3
        bus.fab_rsp_valid = 1'b1;
        bus.fab_rsp_data  = 32'h1234_5678;
        next_cycle();                                   // cycle 4
        bus.fab_rsp_valid = 1'b0;
        bus.fab_rsp_data  = 32'd0;
        @(negedge clk);
        chk("t1_rsp_cycle4", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd1);

        // Stalled write on r1: fields hold for 4 cycles
        next_cycle();
        gq.push_back(1);
        push_rsp(1, 32'd0, 1'b0);
        bus.fab_rsp_stall = 1'b1;
        bus.r1_req_valid  = 1'b1;
        bus.r1_req_opcode = WR_OP;
        bus.r1_req_addr   = 32'h0000_0040;
        bus.r1_req_data   = 32'hA5A5_A5A5;
        wait_any_ready(who, w);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) bus.r1_req_valid = 1'b0;
            if (c == 4) bus.fab_rsp_stall = 1'b0;
            @(negedge clk);
            chk($sformatf("t2_hold_valid_c%0d", c), {31'd0, bus.fab_req_valid}, 32'd1);
            chk($sformatf("t2_hold_addr_c%0d", c), bus.fab_req_addr, 32'h0000_0040);
            chk($sformatf("t2_hold_data_c%0d", c), bus.fab_req_data, 32'hA5A5_A5A5);
        end
        next_cycle();                                   // cycle 5
        @(negedge clk);
        chk("t2_rsp_cycle5", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd2);
        chk("t2_fab_valid_drop", {31'd0, bus.fab_req_valid}, 32'd0);

        // Round robin with both requesters reading continuously
        next_cycle();
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        push_rsp(0, 32'h0200_C0DE, 1'b0);
        push_rsp(1, 32'h0300_C0DE, 1'b0);
        push_rsp(0, 32'h0204_C0DE, 1'b0);
        push_rsp(1, 32'h0304_C0DE, 1'b0);
        n0 = 0;
        n1 = 0;
        bus.r0_req_valid  = 1'b1;
        bus.r0_req_opcode = RD_OP;
        bus.r0_req_addr   = 32'h0000_0200;
        bus.r1_req_valid  = 1'b1;
        bus.r1_req_opcode = RD_OP;
        bus.r1_req_addr   = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(who, w);
            if (who < 0) break;
            if (k > 0) chk($sformatf("t3_read_spacing_%0d", k), w, 32'd1);
            next_cycle();                               // cycle 1
            if (who == 0) begin
                n0++;
                if (n0 == 2) bus.r0_req_valid = 1'b0;
                else         bus.r0_req_addr  = bus.r0_req_addr + 32'd4;
            end else begin
                n1++;
                if (n1 == 2) bus.r1_req_valid = 1'b0;
                else         bus.r1_req_addr  = bus.r1_req_addr + 32'd4;
            end
            @(negedge clk);
            a = bus.fab_req_addr;
            next_cycle();                               // cycle 2
            next_cycle();                               // cycle 3
            bus.fab_rsp_valid = 1'b1;
            bus.fab_rsp_data  = {a[15:0], 16'hC0DE};
            next_cycle();                               // cycle 4
            bus.fab_rsp_valid = 1'b0;
            bus.fab_rsp_data  = 32'd0;
            @(negedge clk);
        end
        bus.r0_req_valid = 1'b0;
        bus.r1_req_valid = 1'b0;

        // Timeout on r0, then a late reply is only a stray
        next_cycle();
        gq.push_back(0);
        push_rsp(0, ERR_DATA, 1'b1);
        bus.r0_req_valid  = 1'b1;
        bus.r0_req_opcode = RD_OP;
        bus.r0_req_addr   = 32'h0000_0500;
        wait_any_ready(who, w);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            next_cycle();
            if (c == 1) bus.r0_req_valid = 1'b0;
            @(negedge clk);
            if (bus.r0_rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk("t4_timeout_latency", lat, 32'd18);
        chk("t4_timeout_err", {31'd0, bus.timeout_err}, 32'd1);
        next_cycle();                                   // IDLE
        next_cycle();
        bus.fab_rsp_valid = 1'b1;
        bus.fab_rsp_data  = 32'h0000_0077;
        next_cycle();
        bus.fab_rsp_valid = 1'b0;
        bus.fab_rsp_data  = 32'd0;
        @(negedge clk);
        chk("t4_stray_pulse", {31'd0, bus.stray_rsp}, 32'd1);
        chk("t4_stray_no_rsp", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd0);
        chk("t4_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Response arrives on the expiry cycle: real data wins
        next_cycle();
        gq.push_back(1);
        push_rsp(1, 32'h0000_0001, 1'b0);
        bus.r1_req_valid  = 1'b1;
        bus.r1_req_opcode = RD_OP;
        bus.r1_req_addr   = 32'h0000_0600;
        wait_any_ready(who, w);
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            if (c == 1) bus.r1_req_valid = 1'b0;
            if (c == 17) begin
                bus.fab_rsp_valid = 1'b1;
                bus.fab_rsp_data  = 32'h0000_0001;
            end
        end
        next_cycle();                                   // cycle 18
        bus.fab_rsp_valid = 1'b0;
        bus.fab_rsp_data  = 32'd0;
        @(negedge clk);
        chk("t5_rsp_cycle18", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd2);
        chk("t5_no_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
        chk("t5_no_stray", {31'd0, bus.stray_rsp}, 32'd0);

        // Reset during WAIT_RSP abandons the read
        next_cycle();
        gq.push_back(0);
        bus.r0_req_valid  = 1'b1;
        bus.r0_req_opcode = RD_OP;
        bus.r0_req_addr   = 32'h0000_0700;
        wait_any_ready(who, w);
        next_cycle();
        bus.r0_req_valid = 1'b0;
        next_cycle();
        next_cycle();                                   // WAIT_RSP
        @(negedge clk);
        chk("t6_busy_before_rst", {31'd0, bus.busy}, 32'd1);
        #1;
        bus.r0_req_valid  = 1'b1;
        bus.r0_req_opcode = WR_OP;
        bus.r0_req_addr   = 32'h0000_0900;
        bus.r0_req_data   = 32'h0000_0011;
        bus.r1_req_valid  = 1'b1;
        bus.r1_req_opcode = WR_OP;
        bus.r1_req_addr   = 32'h0000_0904;
        bus.r1_req_data   = 32'h0000_0022;
        rstn = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_rst_fab_addr", bus.fab_req_addr, 32'd0);
        chk("t6_rst_ready", {30'd0, bus.r1_req_ready, bus.r0_req_ready}, 32'd0);
        next_cycle();
        next_cycle();
        gq.push_back(0);
        gq.push_back(1);
        push_rsp(0, 32'd0, 1'b0);
        push_rsp(1, 32'd0, 1'b0);
        rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_any_ready(who, w);
            if (who < 0) break;
            if (k == 1) chk("t6_write_spacing", w, 32'd1);
            next_cycle();                               // cycle 1 (ISSUE)
            if (who == 0) bus.r0_req_valid = 1'b0;
            else          bus.r1_req_valid = 1'b0;
            if (k == 0) bus.fab_rsp_valid = 1'b1;       // stray during ISSUE
            @(negedge clk);
            chk($sformatf("t6_fab_addr_%0d", k), bus.fab_req_addr,
                (k == 0) ? 32'h0000_0900 : 32'h0000_0904);
            next_cycle();                               // cycle 2 (RESP)
            bus.fab_rsp_valid = 1'b0;
            @(negedge clk);
            if (k == 0) chk("t6_stray_after_rst", {31'd0, bus.stray_rsp}, 32'd1);
        end

        next_cycle();
        next_cycle();
        chk("sb_grants_left", gq.size(), 32'd0);
        chk("sb_rsps_left", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
